mux_scan_sequencer: RTL and testbench

- Upstream control stage for the parameterised 8:1 mux tree.
- Steps the mux's three select bits (s0 = LSB, s2 = MSB) through a programmable subset of the 8 channels.
- Waits a programmable settle time per channel, then registers the mux output with channel tag and valid strobe.
- Provides timed sample capture from the combinational mux for downstream consumers.

---
 rtl/mux_scan_sequencer.sv | 135 +++++++++++++
 tb/tb_mux_scan_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// Select sequencer for an 8:1 mux tree: steps enabled channels, settles, captures.
// Build option SCAN_CONT_EN: restart sweeps continuously until stop or rst.
module mux_scan_sequencer #(
    parameter int N       = 4,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [7:0]         chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [N-1:0]       mux_y,
    output logic               s0,
    output logic               s1,
    output logic               s2,
    output logic [N-1:0]       data_out,
    output logic [2:0]         chan_out,
    output logic               data_valid,
    output logic               sweep_done,
    output logic               busy
);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t             state, state_n;
    logic [2:0]         sel, sel_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [DWELL_W-1:0] dwell_q, dwell_n;
    logic [7:0]         mask_q, mask_n;
    logic [N-1:0]       dout_n;
    logic [2:0]         chan_n;
    logic               dv_n, sd_n;
    logic [2:0]         nxt;

    function automatic logic [2:0] first_en(input logic [7:0] m);
        first_en = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) first_en = 3'(i);
    endfunction

    // ascending search from cur+1, wrapping; k=8 lands back on cur
    function automatic logic [2:0] next_en(input logic [7:0] m,
                                           input logic [2:0] cur);
        logic [2:0] idx;
        logic       found;
        next_en = cur;
        found   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = cur + 3'(k);
            if (m[idx] && !found) begin
                next_en = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign nxt = next_en(mask_q, sel);

    always_comb begin
        state_n = state;
        sel_n   = sel;
        cnt_n   = cnt;
        dwell_n = dwell_q;
        mask_n  = mask_q;
        dout_n  = data_out;
        chan_n  = chan_out;
        dv_n    = 1'b0;
        sd_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop && chan_mask != 8'd0) begin
                    mask_n  = chan_mask;
                    dwell_n = dwell;
                    sel_n   = first_en(chan_mask);
                    cnt_n   = dwell;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    dout_n = mux_y;
                    chan_n = sel;
                    dv_n   = 1'b1;
                    cnt_n  = dwell_q;
                    if (nxt <= sel) begin
                        sd_n = 1'b1;
`ifdef SCAN_CONT_EN
                        sel_n = nxt;
`else
                        state_n = IDLE;
`endif
                    end else begin
                        sel_n = nxt;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 3'd0;
            cnt        <= '0;
            dwell_q    <= '0;
            mask_q     <= 8'd0;
            data_out   <= '0;
            chan_out   <= 3'd0;
            data_valid <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            state      <= state_n;
            sel        <= sel_n;
            cnt        <= cnt_n;
            dwell_q    <= dwell_n;
            mask_q     <= mask_n;
            data_out   <= dout_n;
            chan_out   <= chan_n;
            data_valid <= dv_n;
            sweep_done <= sd_n;
        end
    end

    assign s0   = sel[0];
    assign s1   = sel[1];
    assign s2   = sel[2];
    assign busy = (state == SETTLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomised bench for mux_scan_sequencer; expected captures come from a
// per-sweep schedule (channel list, period, abort edge).
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stop;
    logic [7:0] chan_mask, dwell;
    logic [3:0] mux_y, data_out;
    logic       s0, s1, s2;
    logic [2:0] chan_out;
    logic       data_valid, sweep_done, busy;
    logic [3:0] chdata [8];

    int checks = 0;
    int errors = 0;
    int m_sel  = 0;
    int m_data = 0;
    int m_chan = 0;

    always #5 clk = ~clk;

    assign mux_y = chdata[{s2, s1, s0}];

    mux_scan_sequencer #(.N(4), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .chan_mask(chan_mask), .dwell(dwell), .mux_y(mux_y),
        .s0(s0), .s1(s1), .s2(s2),
        .data_out(data_out), .chan_out(chan_out),
        .data_valid(data_valid), .sweep_done(sweep_done), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    // a < 0: no abort; otherwise stop (or rst) is asserted at relative edge a
    task automatic sweep(input logic [7:0] m, input int d, input int a,
                         input bit use_rst);
        int  lst[$];
        int  n, per, total, ab, end_e, last_e, q, i, ch, x, e_sel;
        bit  sw, aborted, rsted, ev, lastb;
        for (int k = 0; k < 8; k++)
            if (m[k]) lst.push_back(k);
        n     = lst.size();
        per   = d + 1;
        total = n * per;
        ab    = a;
`ifdef SCAN_CONT_EN
        if (ab < 0) ab = 2 * total + 1;
        end_e = ab;
`else
        end_e = (ab >= 0 && ab < total) ? ab : total;
`endif
        sw     = (n != 0) && (ab != 0);
        last_e = ((ab > total) ? ab : total) + 2;
        e_sel  = m_sel;
        for (int e = 0; e <= last_e; e++) begin
            start = (e == 0);
            stop  = (ab == e) && !use_rst;
            rst   = (ab == e) && use_rst;
            if (e == 0) begin
                chan_mask = m;
                dwell     = 8'(d);
            end else begin
                chan_mask = 8'($urandom);
                dwell     = 8'($urandom);
            end
            @(negedge clk);
            aborted = (ab >= 0) && (e >= ab);
            rsted   = aborted && use_rst;
            ev      = 1'b0;
            lastb   = 1'b0;
            i       = (per != 0) ? e / per : 0;
            if (sw && e > 0 && (e % per) == 0 && !aborted) begin
`ifdef SCAN_CONT_EN
                ev = 1'b1;
`else
                ev = (i <= n);
`endif
            end
            if (ev) begin
                ch     = lst[(i - 1) % n];
                lastb  = ((i - 1) % n) == (n - 1);
                m_data = int'(chdata[ch]);
                m_chan = ch;
            end
            if (rsted) begin
                m_data = 0;
                m_chan = 0;
                e_sel  = 0;
            end else if (sw) begin
                x = aborted ? ab - 1 : e;
                q = x / per;
`ifdef SCAN_CONT_EN
                e_sel = lst[q % n];
`else
                e_sel = (q >= n) ? lst[n - 1] : lst[q];
`endif
            end
            chk("data_valid", 32'(data_valid), 32'(ev));
            chk("sweep_done", 32'(sweep_done), 32'(lastb));
            chk("busy", 32'(busy), 32'(sw && e < end_e && !rsted));
            chk("select", 32'({s2, s1, s0}), 32'(e_sel));
            chk("data_out", 32'(data_out), 32'(m_data));
            chk("chan_out", 32'(chan_out), 32'(m_chan));
        end
        start = 1'b0;
        stop  = 1'b0;
        rst   = 1'b0;
        m_sel = e_sel;
    endtask

    initial begin
        int d, kind, tot, a;
        logic [7:0] m;
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        chan_mask = 8'hFF;
        dwell     = 8'd5;
        for (int k = 0; k < 8; k++) chdata[k] = 4'(k + 3);
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_done", 32'(sweep_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sel", 32'({s2, s1, s0}), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_chan", 32'(chan_out), 0);
        rst = 1'b0;

        sweep(8'hFF, 0, -1, 1'b0);
        sweep(8'hA4, 2, -1, 1'b0);
        sweep(8'h10, 1, -1, 1'b0);
        sweep(8'h00, 3, -1, 1'b0);
        sweep(8'hFF, 0, 0, 1'b0);
        sweep(8'hFF, 3, 8, 1'b0);
        sweep(8'hFF, 1, 11, 1'b1);
        sweep(8'h28, 0, -1, 1'b0);
        sweep(8'h81, 255, -1, 1'b0);

        for (int r = 0; r < 14; r++) begin
            for (int k = 0; k < 8; k++) chdata[k] = 4'($urandom);
            m    = 8'($urandom);
            d    = $urandom_range(0, 4);
            kind = $urandom_range(0, 2);
            tot  = $countones(m) * (d + 1);
            a    = (kind == 0 || tot == 0) ? -1 : $urandom_range(1, tot + 1);
            sweep(m, d, a, kind == 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
